// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matrix-multiply engine.
package matmul_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 6;
  localparam int DEFAULT_VECTOR_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module bram_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // A read of the address being written returns the old contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/matmul_top.sv
// Z = X*Y on NxN row-major matrices held in three SDP RAMs, one MAC per cycle.
//
// state      | meaning
// ST_IDLE    | waiting for start after reset
// ST_COMPUTE | issuing X/Y reads and accumulating, writing one Z element per N products
// ST_DONE    | Z valid, done=1, start launches another run
module matmul_top
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] x_wr_addr,
  input  logic                  x_wr_en,
  input  logic [DATA_WIDTH-1:0] x_din,
  input  logic [ADDR_WIDTH-1:0] y_wr_addr,
  input  logic                  y_wr_en,
  input  logic [DATA_WIDTH-1:0] y_din,
  input  logic [ADDR_WIDTH-1:0] z_rd_addr,
  output logic [DATA_WIDTH-1:0] z_dout
);

  localparam logic [ADDR_WIDTH-1:0] N    = ADDR_WIDTH'(VECTOR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VECTOR_SIZE - 1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] row, col, k;
  logic [ADDR_WIDTH-1:0] x_rd_addr, y_rd_addr, z_addr_q;
  logic [DATA_WIDTH-1:0] x_rd_data, y_rd_data, prod, acc, z_wr_data;
  logic                  rd_valid, rd_last, drain;
  logic                  k_last, issue_last, z_wr_en;

  assign k_last     = (k == LAST);
  assign issue_last = k_last && (col == LAST) && (row == LAST);
  assign x_rd_addr  = row * N + k;
  assign y_rd_addr  = k * N + col;
  assign prod       = x_rd_data * y_rd_data;
  assign z_wr_data  = acc + prod;
  assign z_wr_en    = (state == ST_COMPUTE) && rd_valid && rd_last;
  assign done       = (state == ST_DONE);

  // rd_* tracks the read issued last cycle; drain stops issuing once (N-1,N-1,N-1) is out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      k        <= '0;
      acc      <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      drain    <= 1'b0;
      z_addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_COMPUTE;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            acc      <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            drain    <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          rd_valid <= !drain;
          rd_last  <= k_last;
          z_addr_q <= row * N + col;
          if (!drain) begin
            if (k_last) begin
              k <= '0;
              if (col == LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
            if (issue_last) drain <= 1'b1;
          end
          if (rd_valid) begin
            if (rd_last) begin
              acc <= '0;
              if (drain) state <= ST_DONE;
            end else begin
              acc <= acc + prod;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bram_sdp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_x_ram (
    .clock   (clock),
    .wr_en   (x_wr_en),
    .wr_addr (x_wr_addr),
    .wr_data (x_din),
    .rd_addr (x_rd_addr),
    .rd_data (x_rd_data)
  );

  bram_sdp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_y_ram (
    .clock   (clock),
    .wr_en   (y_wr_en),
    .wr_addr (y_wr_addr),
    .wr_data (y_din),
    .rd_addr (y_rd_addr),
    .rd_data (y_rd_data)
  );

  // Host owns the Z read port; the engine only writes Z.
  bram_sdp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_z_ram (
    .clock   (clock),
    .wr_en   (z_wr_en),
    .wr_addr (z_addr_q),
    .wr_data (z_wr_data),
    .rd_addr (z_rd_addr),
    .rd_data (z_dout)
  );

endmodule

// File: tb/tb_matmul_top.sv
// Bench for matmul_top: directed matrices, reference product model, Z readback compare.
module tb_matmul_top;

  localparam int N  = 8;
  localparam int NN = N * N;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [5:0]  x_wr_addr = '0;
  logic        x_wr_en = 1'b0;
  logic [31:0] x_din = '0;
  logic [5:0]  y_wr_addr = '0;
  logic        y_wr_en = 1'b0;
  logic [31:0] y_din = '0;
  logic [5:0]  z_rd_addr = '0;
  logic [31:0] z_dout;

  logic [31:0] mx [NN];
  logic [31:0] my [NN];
  logic [31:0] exp_z [NN];

  int   checks = 0;
  int   failures = 0;
  logic rd_req = 1'b0;
  logic [5:0] cap_addr;
  logic       cap_v;

  matmul_top dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .x_wr_addr (x_wr_addr),
    .x_wr_en   (x_wr_en),
    .x_din     (x_din),
    .y_wr_addr (y_wr_addr),
    .y_wr_en   (y_wr_en),
    .y_din     (y_din),
    .z_rd_addr (z_rd_addr),
    .z_dout    (z_dout)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference: plain triple loop with 32-bit wrapping arithmetic.
  function automatic void model();
    logic [31:0] sum;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sum = '0;
        for (int kk = 0; kk < N; kk++) sum += mx[r*N+kk] * my[kk*N+c];
        exp_z[r*N+c] = sum;
      end
  endfunction

  // Compare process: z_dout one cycle after the address was presented.
  always @(posedge clock) begin
    cap_addr = z_rd_addr;
    cap_v    = rd_req;
    #2;
    if (cap_v) check($sformatf("z[%0d]", cap_addr), z_dout, exp_z[cap_addr]);
  end

  task automatic load(input bit wx, input bit wy);
    for (int i = 0; i < NN; i++) begin
      @(negedge clock);
      x_wr_en = wx; y_wr_en = wy;
      x_wr_addr = 6'(i); y_wr_addr = 6'(i);
      x_din = mx[i]; y_din = my[i];
    end
    @(negedge clock);
    x_wr_en = 1'b0; y_wr_en = 1'b0;
  endtask

  task automatic run(input int pulse_at, output int lat);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    check("done_drop", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 600) begin
      @(negedge clock);
      lat++;
      start = (lat == pulse_at);
    end
    start = 1'b0;
    check("done_rise", {31'd0, done}, 32'd1);
    check("latency_le_520", {31'd0, lat <= 520}, 32'd1);
  endtask

  task automatic read_all();
    for (int a = 0; a < NN; a++) begin
      @(negedge clock);
      z_rd_addr = 6'(a);
      rd_req = 1'b1;
    end
    @(negedge clock) rd_req = 1'b0;
  endtask

  task automatic peek(input int a, output logic [31:0] v);
    @(negedge clock) z_rd_addr = 6'(a);
    @(negedge clock) v = z_dout;
  endtask

  initial begin
    int lat0, lat;
    logic [31:0] v;

    repeat (3) @(negedge clock);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    // Identity times arbitrary
    for (int i = 0; i < NN; i++) begin
      mx[i] = (i / N == i % N) ? 32'd1 : 32'd0;
      my[i] = 32'(i * 37 + 5);
    end
    load(1, 1); model();
    run(-1, lat0);
    read_all();
    peek(19, v); check("ident_z19", v, 32'd708);
    peek(63, v); check("ident_z63", v, 32'd2336);

    // All ones
    for (int i = 0; i < NN; i++) begin mx[i] = 32'd1; my[i] = 32'd1; end
    load(1, 1); model();
    run(-1, lat);
    read_all();
    peek(0, v);  check("ones_z0", v, 32'h8);
    peek(63, v); check("ones_z63", v, 32'h8);

    // Product wrap
    for (int i = 0; i < NN; i++) begin mx[i] = 32'h0001_0000; my[i] = 32'h0001_0000; end
    load(1, 1); model();
    run(-1, lat);
    read_all();
    peek(27, v); check("wrap_prod_z27", v, 32'h0);

    // Accumulator wrap
    for (int i = 0; i < NN; i++) begin mx[i] = 32'hFFFF_FFFF; my[i] = 32'h1; end
    load(1, 1); model();
    run(-1, lat);
    read_all();
    peek(45, v); check("wrap_acc_z45", v, 32'hFFFF_FFF8);

    // start pulsed mid-compute is ignored
    for (int i = 0; i < NN; i++) begin mx[i] = 32'(i + 1); my[i] = 32'(2 * i + 3); end
    load(1, 1); model();
    run(100, lat);
    check("latency_pulse_same", 32'(lat), 32'(lat0));
    read_all();
    peek(0, v); check("pulse_z0", v, 32'd2796);

    // Back-to-back: reload Y only while in DONE
    for (int i = 0; i < NN; i++) my[i] = 32'(i) ^ 32'hA5;
    load(0, 1); model();
    run(-1, lat);
    read_all();
    peek(0, v); check("b2b_z0", v, 32'd5620);

    // Reset from DONE drops done asynchronously
    @(negedge clock) reset = 1'b0;
    #1 check("reset_from_done", {31'd0, done}, 32'd0);
    @(negedge clock) reset = 1'b1;

    // Reset mid-compute aborts; a fresh run still gives the right Z
    for (int i = 0; i < NN; i++) mx[i] = 32'(3 * i + 1);
    load(1, 0); model();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (50) @(negedge clock);
    reset = 1'b0;
    #1 check("reset_mid_done", {31'd0, done}, 32'd0);
    @(negedge clock) reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_after_reset", {31'd0, done}, 32'd0);
    run(-1, lat);
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
